muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO write path of the pipeline.
- Sequences an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Issues a one-cycle HI/LO write pulse with the results.
- Raises an ID-stage stall while an operation is in flight and the decoded instruction reads HI or LO; the hazard unit ORs this into its bubble signal.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  request from EX stage, accepted only in IDLE
- op  input  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- src_a  input  DATA_W  multiplicand or dividend
- src_b  input  DATA_W  multiplier or divisor
- flush  input  1  abort the in-flight operation (exception or redirect)
- hi_used_id  input  1  ID-stage instruction reads HI
- lo_used_id  input  1  ID-stage instruction reads LO
- busy  output  1  state != IDLE
- stall_id  output  1  (hi_used_id | lo_used_id) & busy
- hiwrite  output  1  one-cycle HI write enable
- lowrite  output  1  one-cycle LO write enable
- hi_out  output  DATA_W  HI result, valid when hiwrite=1
- lo_out  output  DATA_W  LO result, valid when lowrite=1

Behaviour:
- Reset values: state IDLE, busy=0, hiwrite=0, lowrite=0, hi_out=0, lo_out=0, iteration counter=0.
- States and transitions:
  - IDLE: on start & !flush, latch operands, clear the counter, go to MUL (op[0]=0) or DIV (op[0]=1).
  - MUL: 64-bit accumulator. Each cycle, if the multiplier LSB is set, add the multiplicand to the upper half, then shift right 1. After DATA_W iterations go to DONE.
  - DIV: 2*DATA_W remainder:quotient register. Each cycle shift left 1 and trial-subtract the divisor from the upper half. If the result is non-negative, keep it and set the quotient LSB. After DATA_W iterations go to DONE.
  - DONE: hiwrite=lowrite=1 for exactly this cycle; HI = product high or remainder, LO = product low or quotient; next state IDLE.
- Latency: start accepted at cycle 0, computation in cycles 1..DATA_W, DONE at cycle DATA_W+1 (33). HI/LO registers update at the end of DONE.
- Divide by zero: DIV goes straight to DONE at cycle 1 with hi_out=src_a and lo_out=all ones.
- stall_id is asserted in MUL, DIV and DONE. It drops in the first IDLE cycle, after HI/LO have been written; no bypass path exists.
- start while busy is ignored; no queueing.
- start with flush in the same IDLE cycle is dropped (flush wins).
- flush in MUL/DIV/DONE: next state IDLE with no hiwrite/lowrite pulse. A flush during DONE does not suppress the pulse already on the outputs in that cycle.
- Reset mid-operation: IDLE next cycle, no write pulse.
- Counter width is clog2(DATA_W)+1; the counter saturates and never wraps.

Optional Feature:
- MULDIV_SIGNED_EN defined:
  - op[1]=1 selects signed operation. Operands are converted to magnitudes at latch time.
  - In DONE, the product or quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- MULDIV_SIGNED_EN undefined: op[1] is ignored and all operations are unsigned; no sign logic is synthesized.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encoding constants
  - the state enum (IDLE, MUL, DIV, DONE)
  - the MULDIV_ITERS constant
- One sub-module, muldiv_iter_dp, holds the accumulator/remainder register, adder/subtractor and shift logic, driven by step/load/mode from this FSM.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: hiwrite/lowrite pulse at cycle 33 with hi_out=0xFFFFFFFE, lo_out=0x00000001; busy low at cycle 34.
- DIVU 100 / 7: at cycle 33, lo_out=14, hi_out=2.
- DIVU 0x1234 / 0: DONE at cycle 1 with hi_out=0x1234, lo_out=0xFFFFFFFF.
- hi_used_id=1 held from cycle 5: stall_id=1 through cycle 33 and 0 at cycle 34; with hi_used_id=0 and lo_used_id=0, stall_id=0 throughout.
- flush at cycle 10 of MULTU: no write pulse ever; busy=0 at cycle 11. A new start at cycle 12 is accepted. A start at cycle 20 of a running op is ignored.
- DIV -7 / 2 (op=11): with MULDIV_SIGNED_EN, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Without it, the operation is DIVU 0xFFFFFFF9/2, giving lo_out=0x7FFFFFFC, hi_out=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide HI/LO controller:
// op encoding, FSM state enum and iteration count.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // op[0] selects divide, op[1] selects signed (only with MULDIV_SIGNED_EN)
  localparam int unsigned OP_DIV_BIT  = 0;
  localparam int unsigned OP_SIGN_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } dp_mode_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiplier / restoring divider, one bit per step.
// Exposes the next-state accumulator so the controller can capture the final step.
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = MULDIV_ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  dp_mode_e          mode_i,
  input  logic [DATA_W-1:0] lo_init_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W-1:0] nxt_hi_c,
  output logic [DATA_W-1:0] nxt_lo_c
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // remainder < divisor, so a successful trial difference always fits DATA_W bits
    div_diff  = div_shift[DATA_W-1:0] - opnd_q;

    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = lo_init_i;
      opnd_d = opnd_i;
    end else if (step_i) begin
      if (mode_i == MODE_MUL) begin
        hi_d = mul_sum[DATA_W:1];
        lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
      end else begin
        hi_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], div_ge};
      end
    end
  end

  assign nxt_hi_c = hi_d;
  assign nxt_lo_c = lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MUL/DIV controller owning the HI/LO write path and ID-stage stall.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV selected by op[1].
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = MULDIV_ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              hi_used_id,
  input  logic              lo_used_id,
  output logic              busy,
  output logic              stall_id,
  output logic              hiwrite,
  output logic              lowrite,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              wr_q;
  logic [DATA_W-1:0] hi_out_q, hi_out_d;
  logic [DATA_W-1:0] lo_out_q, lo_out_d;

  logic              dp_load;
  logic              dp_step;
  dp_mode_e          dp_mode;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] dp_lo_init, dp_opnd;
  logic [DATA_W-1:0] nxt_hi, nxt_lo;
  logic [DATA_W-1:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;

  // Magnitudes at latch time; result signs remembered for the DONE fix-up
  always_comb begin
    a_neg     = op[OP_SIGN_BIT] & src_a[DATA_W-1];
    b_neg     = op[OP_SIGN_BIT] & src_b[DATA_W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (state_q == IDLE && start && !flush) begin
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
    end
  end

  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
    if (state_q == MUL && neg_res_q) begin
      {res_hi, res_lo} = -{nxt_hi, nxt_lo};
    end else if (state_q == DIV) begin
      if (neg_res_q) res_lo = -nxt_lo;
      if (neg_rem_q) res_hi = -nxt_hi;
    end
  end
`else
  logic unused_op_sign;
  assign unused_op_sign = op[OP_SIGN_BIT];

  always_comb begin
    a_mag  = src_a;
    b_mag  = src_b;
    res_hi = nxt_hi;
    res_lo = nxt_lo;
  end
`endif

  // Multiply keeps the multiplier in the low half; divide keeps the dividend there
  always_comb begin
    dp_lo_init = op[OP_DIV_BIT] ? a_mag : b_mag;
    dp_opnd    = op[OP_DIV_BIT] ? b_mag : a_mag;
    dp_mode    = (state_q == DIV) ? MODE_DIV : MODE_MUL;
  end

  muldiv_iter_dp #(
    .DATA_W(DATA_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .mode_i   (dp_mode),
    .lo_init_i(dp_lo_init),
    .opnd_i   (dp_opnd),
    .nxt_hi_c (nxt_hi),
    .nxt_lo_c (nxt_lo)
  );

  // Next-state and control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    hi_out_d = hi_out_q;
    lo_out_d = lo_out_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          cnt_d   = '0;
          dp_load = 1'b1;
          if (!op[OP_DIV_BIT]) begin
            state_d = MUL;
          end else if (src_b == '0) begin
            state_d  = DONE;
            hi_out_d = src_a;
            lo_out_d = '1;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          dp_step = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            hi_out_d = res_hi;
            lo_out_d = res_lo;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      hi_out_q <= '0;
      lo_out_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
      wr_q     <= (state_d == DONE);
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign stall_id = (hi_used_id | lo_used_id) & busy_q;
  assign hiwrite  = wr_q;
  assign lowrite  = wr_q;
  assign hi_out   = hi_out_q;
  assign lo_out   = lo_out_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush, hi_used_id, lo_used_id;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_id, hiwrite, lowrite;
  logic [31:0] hi_out, lo_out;

  int    total = 0;
  int    bad   = 0;
  int    cur_cyc = 0;
  string cur_tag = "init";

  muldiv_hilo_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .hi_used_id(hi_used_id),
    .lo_used_id(lo_used_id),
    .busy      (busy),
    .stall_id  (stall_id),
    .hiwrite   (hiwrite),
    .lowrite   (lowrite),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s cyc=%0d got=%b exp=%b", cur_tag, tag, cur_cyc, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s cyc=%0d got=%h exp=%h", cur_tag, tag, cur_cyc, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output int lat);
    logic        sg;
    longint      sa, sb, q, r;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sg = o[1];
`else
    sg = o[1] & 1'b0;
`endif
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 33;
    if (!o[0]) begin
      if (sg) p = 64'(sa * sb);
      else    p = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      lat = 1;
      eh  = a;
      el  = 32'hFFFF_FFFF;
    end else if (sg) begin
      q  = sa / sb;
      r  = sa % sb;
      el = 32'(q);
      eh = 32'(r);
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at cycle 0 and check every cycle through the first IDLE cycle.
  // flush_at=0 means no flush; inj=1 injects a single start at cycle 20.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic uh, input logic ul,
                        input int flush_at, input bit inj);
    logic [31:0] eh, el;
    int          lat, stop;
    bit          wr_exp, pulse;
    cur_tag = tag;
    model(o, a, b, eh, el, lat);
    stop   = (flush_at > 0 && flush_at < lat) ? flush_at : lat;
    wr_exp = (flush_at == 0 || flush_at >= lat);
    op = o; src_a = a; src_b = b; start = 1'b1; flush = 1'b0;
    hi_used_id = 1'b0; lo_used_id = 1'b0;
    cur_cyc = 0;
    tick();
    for (int c = 1; c <= stop + 1; c++) begin
      cur_cyc = c;
      src_a = $urandom;
      src_b = $urandom;
      op    = 2'($urandom);
      start = inj ? (c == 20 && c <= stop) : (c <= stop && $urandom_range(0, 3) == 0);
      flush = (c == flush_at);
      if (c == 5) begin
        hi_used_id = uh;
        lo_used_id = ul;
      end
      #1;
      pulse = wr_exp && (c == lat);
      chk1("busy", busy, c <= stop);
      chk1("stall", stall_id, (c >= 5) && (c <= stop) && (uh || ul));
      chk1("hiwrite", hiwrite, pulse);
      chk1("lowrite", lowrite, pulse);
      if (pulse) begin
        chk32("hi_out", hi_out, eh);
        chk32("lo_out", lo_out, el);
      end
      if (c <= stop) tick();
    end
    start = 1'b0; flush = 1'b0; hi_used_id = 1'b0; lo_used_id = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0; hi_used_id = 1'b0; lo_used_id = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    hi_used_id = 1'b1;
    #1;
    cur_tag = "reset";
    chk1("busy", busy, 1'b0);
    chk1("stall", stall_id, 1'b0);
    chk1("hiwrite", hiwrite, 1'b0);
    chk1("lowrite", lowrite, 1'b0);
    chk32("hi_out", hi_out, 32'd0);
    chk32("lo_out", lo_out, 32'd0);
    hi_used_id = 1'b0;
    tick();

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
    tick();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b0);
    tick();
    run_op("divu_by0", 2'b01, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    run_op("multu_flush10", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 10, 1'b0);
    tick();
    run_op("after_flush", 2'b00, 32'd3, 32'd5, 1'b0, 1'b1, 0, 1'b0);
    tick();
    run_op("ignore_start", 2'b01, 32'hDEAD_BEEF, 32'd13, 1'b1, 1'b1, 0, 1'b1);
    tick();
    run_op("flush_done", 2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 33, 1'b0);
    tick();
    run_op("flush_last", 2'b01, 32'd77, 32'd5, 1'b0, 1'b0, 32, 1'b0);
    tick();
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0, 1'b0);
    tick();
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
    tick();
    run_op("mult_neg", 2'b10, 32'hFFFF_FFFD, 32'd6, 1'b0, 1'b0, 0, 1'b0);
    tick();

    // start together with flush in IDLE is dropped
    cur_tag = "start_flush";
    op = 2'b00; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cur_cyc = c;
      chk1("busy", busy, 1'b0);
      chk1("hiwrite", hiwrite, 1'b0);
      tick();
    end

    // reset mid-operation: back to IDLE, no pulse, outputs cleared
    cur_tag = "reset_mid";
    op = 2'b00; src_a = 32'd11; src_b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 16; c <= 40; c++) begin
      cur_cyc = c;
      chk1("busy", busy, 1'b0);
      chk1("hiwrite", hiwrite, 1'b0);
      if (c == 16) begin
        chk32("hi_out", hi_out, 32'd0);
        chk32("lo_out", lo_out, 32'd0);
      end
      tick();
    end

    for (int n = 0; n < 24; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          fa;
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
      run_op($sformatf("rand%0d", n), ro, ra, rb, 1'($urandom), 1'($urandom), fa, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
